// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared types and constants for the load/store stage.
//   mem_size_t  : access size code driven by the control unit (3 behaves as word)
//   mau_state_t : bus sequencing state of mem_access_unit
//   WORD_BYTES  : width of the data bus in bytes
package mem_access_unit_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Word-wide, ack-handshaked data bus between the load/store stage and memory.
//   bus_req   : request, held until bus_ack
//   bus_we    : 1 = write access
//   bus_addr  : word-aligned byte address
//   bus_be    : byte enables, one per lane
//   bus_wdata : lane-replicated store data
//   bus_ack   : access complete, bus_rdata valid in the same cycle
//   bus_rdata : read word
//   master modport is the load/store stage, slave modport is the memory side.
interface mem_access_unit_if;

    logic                                       bus_req;
    logic                                       bus_we;
    logic [31:0]                                bus_addr;
    logic [mem_access_unit_pkg::WORD_BYTES-1:0] bus_be;
    logic [31:0]                                bus_wdata;
    logic                                       bus_ack;
    logic [31:0]                                bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_access_unit_lane_align
//   Purely combinational lane handling for the load/store stage.
//   Store side: st_size/st_addr_lo/st_wdata -> st_be, st_lane_wdata, st_misalign
//   Load side : ld_size/ld_addr_lo/ld_unsigned/ld_rdata -> ld_data (aligned, extended)
//   Lanes are little-endian: byte 0 of the word sits in bits [7:0].
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]            st_size,
    input  logic [1:0]            st_addr_lo,
    input  logic [31:0]           st_wdata,
    output logic [WORD_BYTES-1:0] st_be,
    output logic [31:0]           st_lane_wdata,
    output logic                  st_misalign,
    input  logic [1:0]            ld_size,
    input  logic [1:0]            ld_addr_lo,
    input  logic                  ld_unsigned,
    input  logic [31:0]           ld_rdata,
    output logic [31:0]           ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store data is replicated across every lane so memory only needs the byte enables
    // to place it; size code 3 falls through to the word case.
    always_comb begin
        st_be         = 4'b1111;
        st_lane_wdata = st_wdata;
        st_misalign   = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                st_be         = 4'b0001 << st_addr_lo;
                st_lane_wdata = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lane_wdata = {2{st_wdata[15:0]}};
                st_misalign   = st_addr_lo[0];
            end
            default: begin
                st_misalign   = |st_addr_lo;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it to 32 bits.
    always_comb begin
        ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = ld_rdata;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store stage: turns a load/store request from the core into a single bus
//   access, stalls the core until it completes, and returns the extended load data.
//   clk, rst      : clock and synchronous active-low reset
//   mem_re/mem_we : load / store request (both high = store)
//   mem_size      : 0 byte, 1 half, 2/3 word; mem_unsigned selects zero-extension
//   addr, wdata   : byte address and store data from the datapath
//   read_data     : last completed load result
//   stall         : hold the core this cycle
//   misalign      : pulse, misaligned access dropped
//   bus_err       : pulse, bus access timed out
//   bus           : master side of the data bus
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    mem_access_unit_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    mau_state_t             state;
    logic [CNT_W-1:0]       req_cnt;
    logic [1:0]             ld_size;
    logic [1:0]             ld_addr_lo;
    logic                   ld_unsigned;
    logic                   access;
    logic                   lane_misalign;
    logic [WORD_BYTES-1:0]  st_be;
    logic [31:0]            st_lane_wdata;
    logic [31:0]            ld_data;

    assign access = mem_re | mem_we;

    mem_access_unit_lane_align u_lane_align (
        .st_size       (mem_size),
        .st_addr_lo    (addr[1:0]),
        .st_wdata      (wdata),
        .st_be         (st_be),
        .st_lane_wdata (st_lane_wdata),
        .st_misalign   (lane_misalign),
        .ld_size       (ld_size),
        .ld_addr_lo    (ld_addr_lo),
        .ld_unsigned   (ld_unsigned),
        .ld_rdata      (bus.bus_rdata),
        .ld_data       (ld_data)
    );

    // The stall has to rise in the very cycle the request appears, before any register
    // has seen it, so it is decoded from the current state and inputs.
    assign stall    = (state == REQ) || ((state == IDLE) && access && !lane_misalign);
    assign misalign = (state == IDLE) && access && lane_misalign;

    // Bus sequencer. Load size/offset/sign are latched with the request because the
    // extraction happens later, when bus_ack arrives. Ack wins over timeout when both
    // fall on the last allowed REQ cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            req_cnt       <= '0;
            ld_size       <= 2'd0;
            ld_addr_lo    <= 2'd0;
            ld_unsigned   <= 1'b0;
            read_data     <= 32'd0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= 32'd0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !lane_misalign) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_we;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= st_be;
                        bus.bus_wdata <= st_lane_wdata;
                        ld_size       <= mem_size;
                        ld_addr_lo    <= addr[1:0];
                        ld_unsigned   <= mem_unsigned;
                        req_cnt       <= '0;
                        state         <= REQ;
                    end else if (access) begin
                        read_data     <= 32'd0;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            read_data <= ld_data;
                        end
                        state       <= DONE;
                    end else if (req_cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.bus_req <= 1'b0;
                        read_data   <= 32'd0;
                        bus_err     <= 1'b1;
                        state       <= DONE;
                    end else begin
                        req_cnt     <= req_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit. A transaction-level reference model tracks
//   what the bus and core-facing outputs must be; a compare process checks them on
//   every falling edge, and each directed access also checks hand-computed values.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .read_data    (read_data),
        .stall        (stall),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    // Values observed by doAccess during the last access
    int          sStall;
    int          sReq;
    logic        sMis;
    logic        sWe;
    logic [31:0] sAddr;
    logic [3:0]  sBe;
    logic [31:0] sWdata;
    logic [31:0] sRd;
    logic        sErr;

    // Reference model state
    int          mPhase;    // 0 waiting for a request, 1 bus busy, 2 completing
    int          mWaited;
    logic        mErr;
    logic [31:0] mReadData;
    logic        mWe;
    logic [31:0] mAddr;
    logic [3:0]  mBe;
    logic [31:0] mWdata;
    logic [1:0]  mLdSize;
    logic [31:0] mLdAddr;
    logic        mLdUns;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference helpers expressed as arithmetic on byte counts
    function automatic int nBytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit isMis(input logic [1:0] s, input logic [31:0] a);
        return (int'(a[1:0]) % nBytes(s)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] s, input logic [31:0] a);
        int n;
        int v;
        n = nBytes(s);
        v = ((1 << n) - 1) << ((n == 4) ? 0 : int'(a[1:0]));
        return v[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] s, input logic [31:0] d);
        int n;
        n = nBytes(s);
        if (n == 1) return {24'd0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] s, input logic [31:0] a,
                                              input logic uns, input logic [31:0] rd);
        int          n;
        logic [31:0] v;
        logic [31:0] span;
        n = nBytes(s);
        if (n == 4) return rd;
        span = 32'd1 << (8 * n);
        v = (rd >> (8 * int'(a[1:0]))) & (span - 32'd1);
        if (!uns && v >= (span >> 1)) v = v - span;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd);
        mem_re       = re;
        mem_we       = we;
        mem_size     = size;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
    endtask

    // Issue one access at posedge+1, answer with bus_ack in the ackAt-th REQ cycle
    // (ackAt <= 0 never answers), and return once the stall has dropped.
    task automatic doAccess(input logic re, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input int ackAt, input logic [31:0] rd);
        bit finished = 0;
        sStall = 0; sReq = 0; sMis = 0; sWe = 0; sAddr = 0; sBe = 0; sWdata = 0;
        sRd = 0; sErr = 0;
        applyStimulus(re, we, size, uns, a, wd);
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) begin
                finished = 1;
                sMis = misalign;
                sRd  = read_data;
                sErr = bus_err;
            end else begin
                sStall++;
                if (bus.bus_req === 1'b1) begin
                    sReq++;
                    if (sReq == 1) begin
                        sWe = bus.bus_we; sAddr = bus.bus_addr;
                        sBe = bus.bus_be; sWdata = bus.bus_wdata;
                    end
                    if (sReq == ackAt) begin
                        bus.bus_ack   = 1'b1;
                        bus.bus_rdata = rd;
                    end
                end
                @(posedge clk);
                #1;
                bus.bus_ack = 1'b0;
            end
        end
        if (!finished) checkOutput("accessCompletes", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    endtask

    // Reference model: advances once per rising edge from the spec's access rules.
    always @(posedge clk) begin
        if (!rst) begin
            mPhase = 0; mWaited = 0; mErr = 0; mReadData = 0;
            mWe = 0; mAddr = 0; mBe = 0; mWdata = 0; mLdSize = 0; mLdAddr = 0; mLdUns = 0;
        end else begin
            mErr = 0;
            if (mPhase == 0) begin
                if (mem_re || mem_we) begin
                    if (isMis(mem_size, addr)) begin
                        mReadData = 0;
                    end else begin
                        mPhase  = 1;
                        mWaited = 0;
                        mWe     = mem_we;
                        mAddr   = addr & ~32'd3;
                        mBe     = modelBe(mem_size, addr);
                        mWdata  = modelWdata(mem_size, wdata);
                        mLdSize = mem_size;
                        mLdAddr = addr;
                        mLdUns  = mem_unsigned;
                    end
                end
            end else if (mPhase == 1) begin
                mWaited++;
                if (bus.bus_ack) begin
                    if (!mWe) mReadData = modelLoad(mLdSize, mLdAddr, mLdUns, bus.bus_rdata);
                    mPhase = 2;
                end else if (mWaited == TIMEOUT) begin
                    mReadData = 0;
                    mErr      = 1;
                    mPhase    = 2;
                end
            end else begin
                mPhase = 0;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge once reset is done.
    always @(negedge clk) begin
        if (checkEn) begin
            bit acc;
            bit mis;
            acc = mem_re || mem_we;
            mis = isMis(mem_size, addr);
            checkOutput("stall", {31'd0, stall}, {31'd0, (mPhase == 1) || (mPhase == 0 && acc && !mis)});
            checkOutput("misalign", {31'd0, misalign}, {31'd0, (mPhase == 0) && acc && mis});
            checkOutput("bus_err", {31'd0, bus_err}, {31'd0, mErr});
            checkOutput("bus_req", {31'd0, bus.bus_req}, {31'd0, mPhase == 1});
            checkOutput("read_data", read_data, mReadData);
            if (mPhase == 1) begin
                checkOutput("bus_we", {31'd0, bus.bus_we}, {31'd0, mWe});
                checkOutput("bus_addr", bus.bus_addr, mAddr);
                checkOutput("bus_be", {28'd0, bus.bus_be}, {28'd0, mBe});
                checkOutput("bus_wdata", bus.bus_wdata, mWdata);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        checkEn = 1;

        // Reset state
        @(negedge clk);
        checkOutput("rst_read_data", read_data, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
        checkOutput("rst_bus_be", {28'd0, bus.bus_be}, 32'd0);
        checkOutput("rst_bus_addr", bus.bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus.bus_wdata, 32'd0);
        checkOutput("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1;

        // lw 0x100, ack in second REQ cycle
        doAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 2, 32'hDEADBEEF);
        checkOutput("lw_be", {28'd0, sBe}, 32'h0000000F);
        checkOutput("lw_stall_cycles", sStall, 32'd3);
        checkOutput("lw_read_data", sRd, 32'hDEADBEEF);

        // sb 0x1003
        doAccess(1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000AB, 1, 32'd0);
        checkOutput("sb_be", {28'd0, sBe}, 32'h00000008);
        checkOutput("sb_wdata", sWdata, 32'hABABABAB);
        checkOutput("sb_addr", sAddr, 32'h00001000);
        checkOutput("sb_we", {31'd0, sWe}, 32'd1);
        checkOutput("sb_keeps_read_data", sRd, 32'hDEADBEEF);

        // Sub-word loads
        doAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h2001, 32'd0, 1, 32'h00008000);
        checkOutput("lb_sign", sRd, 32'hFFFFFF80);
        doAccess(1'b1, 1'b0, 2'd0, 1'b1, 32'h2001, 32'd0, 1, 32'h00008000);
        checkOutput("lbu_zero", sRd, 32'h00000080);
        doAccess(1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'd0, 1, 32'h80010000);
        checkOutput("lh_sign", sRd, 32'hFFFF8001);
        doAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h5003, 32'd0, 3, 32'h7F000000);
        checkOutput("lb_positive", sRd, 32'h0000007F);

        // sh upper half
        doAccess(1'b0, 1'b1, 2'd1, 1'b0, 32'h3002, 32'h1234ABCD, 1, 32'd0);
        checkOutput("sh_be", {28'd0, sBe}, 32'h0000000C);
        checkOutput("sh_wdata", sWdata, 32'hABCDABCD);

        // lhu lower half
        doAccess(1'b1, 1'b0, 2'd1, 1'b1, 32'h4000, 32'd0, 1, 32'h1234F00D);
        checkOutput("lhu_zero", sRd, 32'h0000F00D);

        // Misaligned word load is dropped and clears read_data
        doAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h1002, 32'd0, 1, 32'hFFFFFFFF);
        checkOutput("mis_pulse", {31'd0, sMis}, 32'd1);
        checkOutput("mis_no_stall", sStall, 32'd0);
        checkOutput("mis_no_req", sReq, 32'd0);
        checkOutput("mis_read_data", read_data, 32'd0);

        // Size code 3 behaves as a word
        doAccess(1'b1, 1'b0, 2'd3, 1'b0, 32'h6000, 32'd0, 1, 32'h01234567);
        checkOutput("sz3_be", {28'd0, sBe}, 32'h0000000F);
        checkOutput("sz3_read_data", sRd, 32'h01234567);

        // Load and store together means store
        doAccess(1'b1, 1'b1, 2'd2, 1'b0, 32'h7000, 32'h55667788, 1, 32'hFFFFFFFF);
        checkOutput("rw_we", {31'd0, sWe}, 32'd1);
        checkOutput("rw_wdata", sWdata, 32'h55667788);
        checkOutput("rw_keeps_read_data", sRd, 32'h01234567);

        // No ack: timeout after TIMEOUT REQ cycles
        doAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000, 32'd0, 0, 32'd0);
        checkOutput("to_req_cycles", sReq, 32'd16);
        checkOutput("to_stall_cycles", sStall, 32'd17);
        checkOutput("to_bus_err", {31'd0, sErr}, 32'd1);
        checkOutput("to_read_data", sRd, 32'd0);

        // Put a non-zero value in read_data, then reset in the middle of REQ
        doAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h8800, 32'd0, 1, 32'hCAFEF00D);
        checkOutput("pre_rst_read_data", sRd, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h9000, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_bus_req", {31'd0, bus.bus_req}, 32'd0);
        checkOutput("rst_mid_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
        #1;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_read_data", read_data, 32'd0);
        checkOutput("late_ack_bus_req", {31'd0, bus.bus_req}, 32'd0);
        checkOutput("late_ack_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1;

        checkEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
